counter_apb_bank: RTL
=====================

// Module: counter_apb_bank
// PURPOSE
//  APB3 slave holding NUM_CH independent up/down counters, each with its own enable, direction,
//  reload value, limit, one-shot mode and sticky terminal-count flag. Flags drive a per-channel
//  tc pulse and one combined, maskable irq. Sits on the peripheral APB bus as a multi-channel timer bank.
// PARAMETERS
//  WIDTH       32      counter/LOAD/LIMIT width, 1..32; reads zero-extend, writes truncate to WIDTH
//  NUM_CH      4       number of channels, 1..16
//  BASE_ADDR   32'h0   byte base address of the register map
//  PRESCALE_W  16      prescaler width (used only with COUNTER_APB_PRESCALER_EN)
// PORTS
//  pclk     in   1        clock; all logic on rising edge
//  preset   in   1        reset, synchronous, active-high
//  paddr    in   32       APB byte address
//  pwdata   in   32       APB write data
//  pwrite   in   1        1 = write
//  psel     in   1        APB select
//  penable  in   1        APB access phase
//  prdata   out  32       read data; valid in access phase, 32'h0 otherwise
//  pready   out  1        tied 1 (zero wait states)
//  pslverr  out  1        error response, access phase only
//  tc       out  NUM_CH   1-cycle pulse per channel on terminal count
//  irq      out  1        |(STATUS & irq_en), level
// BEHAVIOUR
//  Map (offset from BASE_ADDR): channel i at 0x10*i: +0x0 CTRL RW, +0x4 LOAD RW, +0x8 LIMIT RW,
//   +0xC COUNT RO. Global: 0x100 STATUS (bit i = ch i flag, W1C), 0x104 PRESC RW (macro only).
//  CTRL bits: [0] en, [1] dir (1=up, 0=down), [2] oneshot, [3] irq_en, [4] load (write-only strobe,
//   reads 0). Other bits read 0.
//  Reset: CTRL/LOAD/COUNT/STATUS = 0, LIMIT = all-ones(WIDTH), prescaler = 0; prdata/pslverr/tc/irq = 0.
//  APB: write commits on the pclk edge where psel&penable&pwrite; read data combinational in the same
//   access phase. pslverr=1 in access phase for: unmapped offset, channel index >= NUM_CH,
//   paddr[1:0]!=0, write to COUNT. Errored writes change no state. Setup phase has no side effects.
//  Tick: with en=1, counter steps once per tick (every cycle without the macro).
//  Up: COUNT==LIMIT -> terminal event, next = LOAD; else COUNT+1.
//  Down: COUNT==0 -> terminal event, next = LOAD if LOAD!=0 else LIMIT; else COUNT-1.
//  COUNT>LIMIT while counting up (LIMIT lowered below COUNT): counts on to all-ones, wraps mod 2^WIDTH
//   to 0, then reaches LIMIT; no terminal event at the 2^WIDTH wrap.
//  Terminal event: tc[i] pulses one cycle after the step; STATUS[i] set. Oneshot=1: COUNT holds
//   terminal value (LIMIT up / 0 down) and CTRL.en clears in the same edge.
//  CTRL write with load=1: COUNT <= LOAD on that edge; load beats a same-cycle tick (no step, no tc).
//  Same-cycle STATUS W1C and new terminal event on that bit: set wins.
//  dir change takes effect on the next tick; en=0 freezes COUNT, STATUS preserved.
//  preset mid-operation: all state to reset values on that edge; an APB access in flight is dropped.
// CONFIGURATION
//  COUNTER_APB_PRESCALER_EN defined: PRESC register (PRESCALE_W bits) at 0x104; a shared prescaler
//   produces a tick every PRESC+1 pclk cycles; prescaler restarts at 0 when PRESC written.
//   Ticks pace all enabled channels together.
//  Not defined: tick every pclk; offset 0x104 is unmapped (read 0, pslverr=1).
// TESTING
//  1 Reset, read ch0 LIMIT -> 32'hFFFF_FFFF, CTRL/COUNT/STATUS -> 0, irq=0, pslverr=0.
//  2 ch1 LIMIT=3, CTRL=0x0B (en,up,irq_en) -> COUNT 0,1,2,3,0; tc[1] pulse after 3->0;
//    STATUS=0x2, irq=1; write STATUS=0x2 -> irq=0.
//  3 ch0 LOAD=5, CTRL=0x15 (load,en,oneshot,down) -> COUNT 5..0, holds 0, CTRL reads 0x4, STATUS[0]=1.
//  4 Read COUNT of ch NUM_CH, write ch0 COUNT, paddr=BASE+0x2 -> pslverr=1, prdata=0, no state change.
//  5 Same-cycle STATUS W1C and ch0 terminal event -> STATUS[0] remains 1.
//  6 Macro on: PRESC=2, ch0 up, en -> COUNT increments every 3 pclk; macro off: 0x104 -> pslverr=1.

Source files
------------

// File: rtl/counter_apb_bank.sv
// counter_apb_bank: APB3 slave with NUM_CH up/down counters, sticky terminal-count flags, tc pulses and a maskable irq.
// Define COUNTER_APB_PRESCALER_EN to add the shared PRESC register at 0x104 that paces the counter ticks.
module counter_apb_bank #(
  parameter int          WIDTH      = 32,
  parameter int          NUM_CH     = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          PRESCALE_W = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [31:0]       paddr,
  input  logic [31:0]       pwdata,
  input  logic              pwrite,
  input  logic              psel,
  input  logic              penable,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [NUM_CH-1:0] tc,
  output logic              irq
);

  logic [31:0] off;
  logic [3:0]  ch_sel;
  logic [1:0]  reg_sel;
  logic        acc, is_ch, is_stat, is_presc, err, wr, rd, tick;
  logic        unused_bits;

  logic [WIDTH-1:0]  cnt_v   [NUM_CH];
  logic [WIDTH-1:0]  load_v  [NUM_CH];
  logic [WIDTH-1:0]  limit_v [NUM_CH];
  logic [NUM_CH-1:0] en_v, dir_v, os_v, ie_v, term_p0;
  logic [NUM_CH-1:0] status_q, tc_p1;

  assign off         = paddr - BASE_ADDR;
  assign ch_sel      = off[7:4];
  assign reg_sel     = off[3:2];
  assign acc         = psel & penable;
  assign is_ch       = (off[31:8] == 24'd0) && ({28'd0, ch_sel} < 32'(NUM_CH));
  assign is_stat     = (off == 32'h100);
  assign err         = (paddr[1:0] != 2'b00) | ~(is_ch | is_stat | is_presc) |
                       (is_ch & pwrite & (reg_sel == 2'd3));
  assign wr          = acc & pwrite & ~err;
  assign rd          = acc & ~pwrite & ~err;
  assign pready      = 1'b1;
  assign pslverr     = acc & err;
  assign tc          = tc_p1;
  assign irq         = |(status_q & ie_v);
  assign unused_bits = ^pwdata;

`ifdef COUNTER_APB_PRESCALER_EN
  logic [PRESCALE_W-1:0] presc_q, pcnt_q;

  assign is_presc = (off == 32'h104);
  assign tick     = (pcnt_q == presc_q);

  // Shared prescaler: one tick every PRESC+1 cycles, restarted by a PRESC write.
  always_ff @(posedge pclk) begin
    if (preset) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else if (wr & is_presc) begin
      presc_q <= pwdata[PRESCALE_W-1:0];
      pcnt_q  <= '0;
    end else begin
      pcnt_q  <= tick ? '0 : pcnt_q + PRESCALE_W'(1);
    end
  end
`else
  localparam int unused_presc_w = PRESCALE_W;
  assign is_presc = 1'b0;
  assign tick     = 1'b1;
`endif

  always_comb begin
    prdata = 32'd0;
    if (rd) begin
      if (is_stat) begin
        prdata[NUM_CH-1:0] = status_q;
`ifdef COUNTER_APB_PRESCALER_EN
      end else if (is_presc) begin
        prdata[PRESCALE_W-1:0] = presc_q;
`endif
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_sel == 4'(i)) begin
            case (reg_sel)
              2'd0:    prdata[3:0]       = {ie_v[i], os_v[i], dir_v[i], en_v[i]};
              2'd1:    prdata[WIDTH-1:0] = load_v[i];
              2'd2:    prdata[WIDTH-1:0] = limit_v[i];
              default: prdata[WIDTH-1:0] = cnt_v[i];
            endcase
          end
        end
      end
    end
  end

  // Stage p0 -> p1: terminal events set sticky flags (set beats W1C) and launch tc.
  always_ff @(posedge pclk) begin
    if (preset) begin
      status_q <= '0;
      tc_p1    <= '0;
    end else begin
      status_q <= ((wr & is_stat) ? (status_q & ~pwdata[NUM_CH-1:0]) : status_q) | term_p0;
      tc_p1    <= term_p0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, load_q, limit_q, cnt_nxt;
    logic             en_q, dir_q, os_q, ie_q, term, wr_sel, wr_ctrl, strobe;

    assign wr_sel  = wr & is_ch & (ch_sel == 4'(g));
    assign wr_ctrl = wr_sel & (reg_sel == 2'd0);
    assign strobe  = wr_ctrl & pwdata[4];

    // A load strobe overrides the tick; a one-shot terminal step holds the terminal value.
    always_comb begin
      term    = 1'b0;
      cnt_nxt = cnt_q;
      if (strobe) begin
        cnt_nxt = load_q;
      end else if (en_q & tick) begin
        if (dir_q) begin
          if (cnt_q == limit_q) begin
            term    = 1'b1;
            cnt_nxt = load_q;
          end else begin
            cnt_nxt = cnt_q + WIDTH'(1);
          end
        end else if (cnt_q == '0) begin
          term    = 1'b1;
          cnt_nxt = (load_q != '0) ? load_q : limit_q;
        end else begin
          cnt_nxt = cnt_q - WIDTH'(1);
        end
        if (term & os_q) cnt_nxt = cnt_q;
      end
    end

    always_ff @(posedge pclk) begin
      if (preset) begin
        cnt_q   <= '0;
        load_q  <= '0;
        limit_q <= '1;
        en_q    <= 1'b0;
        dir_q   <= 1'b0;
        os_q    <= 1'b0;
        ie_q    <= 1'b0;
      end else begin
        cnt_q <= cnt_nxt;
        if (wr_sel && reg_sel == 2'd1) load_q  <= pwdata[WIDTH-1:0];
        if (wr_sel && reg_sel == 2'd2) limit_q <= pwdata[WIDTH-1:0];
        if (wr_ctrl) begin
          en_q  <= pwdata[0];
          dir_q <= pwdata[1];
          os_q  <= pwdata[2];
          ie_q  <= pwdata[3];
        end else if (term & os_q) begin
          en_q  <= 1'b0;
        end
      end
    end

    assign cnt_v[g]   = cnt_q;
    assign load_v[g]  = load_q;
    assign limit_v[g] = limit_q;
    assign en_v[g]    = en_q;
    assign dir_v[g]   = dir_q;
    assign os_v[g]    = os_q;
    assign ie_v[g]    = ie_q;
    assign term_p0[g] = term;
  end

endmodule
